// File: rtl/pe_window_feeder.sv
// rtl/pe_window_feeder.sv - 5x5 sliding-window feeder for the PE operand port with result-valid tracking
module pe_window_feeder #(
  parameter int IMG_W  = 32,
  parameter int PE_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         pix_valid,
  output logic         pix_ready,
  input  logic [7:0]   pix_data,
  output logic         win_valid,
  input  logic         win_ready,
  output logic [199:0] win_data,
  output logic         win_last,
  output logic         res_valid,
  output logic         res_last,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(IMG_W);
  localparam logic [CW-1:0] LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] FOUR = CW'(4);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]        state;
  logic [CW-1:0]     col;
  logic [CW-1:0]     row;
  logic [1:0]        wptr;
  logic              remaining;
  logic [PE_LAT-1:0] rv;
  logic [PE_LAT-1:0] rl;

  logic [7:0]   lb      [4][IMG_W];
  logic [7:0]   sh      [5][5];
  logic [7:0]   sh_next [5][5];
  logic [199:0] win_next;

  logic fire;
  logic accept;
  logic load;
  logic last_pix;

  assign fire      = win_valid & win_ready;
  assign pix_ready = ((state == S_FILL) || (state == S_RUN)) & remaining & (~win_valid | win_ready);
  assign accept    = pix_valid & pix_ready;
  assign last_pix  = (row == LAST) && (col == LAST);
  assign load      = accept && (row >= FOUR) && (col >= FOUR);

  assign busy      = (state != S_IDLE);
  assign res_valid = rv[PE_LAT-1];
  assign res_last  = rl[PE_LAT-1];
  assign done      = (state == S_DRAIN) & rl[PE_LAT-1];

  // wptr always points at the oldest buffered row, so wptr+r is row (row-4+r).
  always_comb begin
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        sh_next[r][c] = sh[r][c+1];
      end
    end
    for (int r = 0; r < 4; r++) begin
      sh_next[r][4] = lb[wptr + r[1:0]][col];
    end
    sh_next[4][4] = pix_data;
  end

  always_comb begin
    win_next = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        win_next[8*(5*r+c) +: 8] = sh_next[r][c];
      end
    end
  end

  // Buffer and shift window need no reset: nothing is read before it is rewritten.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb[wptr][col] <= pix_data;
      sh <= sh_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      col       <= '0;
      row       <= '0;
      wptr      <= '0;
      remaining <= 1'b0;
      win_valid <= 1'b0;
      win_data  <= '0;
      win_last  <= 1'b0;
      rv        <= '0;
      rl        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_FILL;
            col       <= '0;
            row       <= '0;
            wptr      <= '0;
            remaining <= 1'b1;
          end
        end
        S_FILL:  if (accept && (row == FOUR) && (col == FOUR)) state <= S_RUN;
        S_RUN:   if (fire && win_last) state <= S_DRAIN;
        default: if (rl[PE_LAT-1]) state <= S_IDLE;
      endcase

      if (accept) begin
        if (last_pix) remaining <= 1'b0;
        if (col == LAST) begin
          col  <= '0;
          row  <= (row == LAST) ? '0 : row + 1'b1;
          wptr <= wptr + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      if (load) begin
        win_valid <= 1'b1;
        win_data  <= win_next;
        win_last  <= last_pix;
      end else if (fire) begin
        win_valid <= 1'b0;
        win_last  <= 1'b0;
      end

      // PE has a fixed latency and never stalls, so a delay line tracks results exactly.
      rv[0] <= fire;
      rl[0] <= fire & win_last;
      for (int i = 1; i < PE_LAT; i++) begin
        rv[i] <= rv[i-1];
        rl[i] <= rl[i-1];
      end
    end
  end

endmodule

// File: tb/tb_pe_window_feeder.sv
// tb/tb_pe_window_feeder.sv - randomized and directed bench for pe_window_feeder against a window-list model
module tb_pe_window_feeder;

  localparam int W = 8;
  localparam int N = W * W;
  localparam int NWIN = (W - 4) * (W - 4);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, pix_valid, pix_ready, win_valid, win_ready, win_last;
  logic         res_valid, res_last, busy, done;
  logic [7:0]   pix_data;
  logic [199:0] win_data;

  logic         start5, pix_valid5, pix_ready5, win_valid5, win_ready5, win_last5;
  logic         res_valid5, res_last5, busy5, done5;
  logic [7:0]   pix_data5;
  logic [199:0] win_data5;

  pe_window_feeder #(.IMG_W(W), .PE_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data), .win_last(win_last),
    .res_valid(res_valid), .res_last(res_last), .busy(busy), .done(done)
  );

  pe_window_feeder #(.IMG_W(5), .PE_LAT(2)) dut5 (
    .clk(clk), .rst(rst), .start(start5),
    .pix_valid(pix_valid5), .pix_ready(pix_ready5), .pix_data(pix_data5),
    .win_valid(win_valid5), .win_ready(win_ready5), .win_data(win_data5), .win_last(win_last5),
    .res_valid(res_valid5), .res_last(res_last5), .busy(busy5), .done(done5)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]   img [N];
  logic [199:0] winq [$];
  logic [199:0] first_w, last_w;
  logic [7:0]   p5 [25];
  logic [199:0] exp5;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_pix_ready"}, pix_ready, 1'b0);
    chk1({tag, "_win_valid"}, win_valid, 1'b0);
    chkw({tag, "_win_data"}, win_data, '0);
    chk1({tag, "_win_last"}, win_last, 1'b0);
    chk1({tag, "_res_valid"}, res_valid, 1'b0);
    chk1({tag, "_res_last"}, res_last, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
  endtask

  // rmode: 0 ready always, 1 stall 5 cycles on the 3rd window, 2 toggle, 3 random
  task automatic run_frame(input int rmode, input bit ramp, input bit rvalid,
                           input int abort_at, input bit restart);
    int idx = 0, nfire = 0, nres = 0, stall = 0, cyc = 0;
    int last_fire_cyc = -1, done_cyc = -1;
    bit exp_wv = 0, fin = 0, wr, pv, exp_pr, fire, acc, ld, lastfire;
    bit [1:0] fh = 2'b00, fl = 2'b00;
    logic [199:0] w;

    for (int k = 0; k < N; k++) img[k] = ramp ? 8'((k / W) * 8 + (k % W)) : 8'($urandom);
    winq.delete();
    for (int oy = 0; oy <= W - 5; oy++) begin
      for (int ox = 0; ox <= W - 5; ox++) begin
        for (int r = 0; r < 5; r++)
          for (int c = 0; c < 5; c++)
            w[8*(5*r+c) +: 8] = img[(oy + r) * W + ox + c];
        winq.push_back(w);
      end
    end

    @(negedge clk);
    chk1("idle_busy", busy, 1'b0);
    start = 1'b1;
    @(negedge clk);

    while (!fin) begin
      if (abort_at > 0 && idx == abort_at) begin
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk);
        pix_valid = 1'b0;
        win_ready = 1'b0;
        start = 1'b0;
        rst = 1'b1;
        return;
      end

      case (rmode)
        1: begin
          wr = !(exp_wv && nfire == 2 && stall < 5);
          if (!wr) stall++;
        end
        2: wr = (cyc % 2 == 0);
        3: wr = ($urandom_range(0, 1) == 1);
        default: wr = 1'b1;
      endcase
      pv = rvalid ? ($urandom_range(0, 3) != 0) : 1'b1;
      win_ready = wr;
      pix_valid = pv;
      pix_data  = (idx < N) ? img[idx] : 8'h00;
      start     = restart && (cyc == 30);
      #1;

      exp_pr = (idx < N) && (!exp_wv || wr);
      chk1("pix_ready", pix_ready, exp_pr);
      chk1("win_valid", win_valid, exp_wv);
      if (exp_wv) begin
        chkw("win_data", win_data, winq[0]);
        chk1("win_last", win_last, winq.size() == 1);
      end
      chk1("res_valid", res_valid, fh[1]);
      chk1("res_last", res_last, fl[1]);
      chk1("done", done, fl[1]);
      chk1("busy", busy, 1'b1);

      fire = exp_wv && wr;
      acc  = pv && exp_pr;
      ld   = acc && (idx / W >= 4) && (idx % W >= 4);
      lastfire = fire && (winq.size() == 1);
      if (fire) begin
        if (nfire == 0) first_w = winq[0];
        last_w = winq[0];
        if (lastfire) last_fire_cyc = cyc;
        void'(winq.pop_front());
        nfire++;
      end
      if (fh[1]) nres++;
      if (fl[1]) begin
        done_cyc = cyc;
        fin = 1'b1;
      end
      fh = {fh[0], fire};
      fl = {fl[0], lastfire};
      exp_wv = ld || (exp_wv && !fire);
      if (acc) idx++;
      cyc++;
      if (cyc > 3000) begin
        checks++;
        errors++;
        $error("FAIL frame_timeout: observed %0d cycles expected at most 3000", cyc);
        fin = 1'b1;
      end
      @(negedge clk);
    end

    win_ready = 1'b0;
    pix_valid = 1'b0;
    start = 1'b0;
    #1;
    chk1("end_busy", busy, 1'b0);
    chk1("end_done", done, 1'b0);
    chk1("end_win_valid", win_valid, 1'b0);
    chki("fire_count", nfire, NWIN);
    chki("res_count", nres, NWIN);
    chki("done_latency", done_cyc - last_fire_cyc, 2);
  endtask

  task automatic chk_ramp_windows();
    chki("first_slot0", int'(first_w[7:0]), 0);
    chki("first_slot4", int'(first_w[39:32]), 4);
    chki("first_slot20", int'(first_w[167:160]), 32);
    chki("first_slot24", int'(first_w[199:192]), 36);
    chki("last_slot0", int'(last_w[7:0]), 27);
    chki("last_slot24", int'(last_w[199:192]), 63);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; pix_valid = 1'b0; win_ready = 1'b0; pix_data = 8'h00;
    start5 = 1'b0; pix_valid5 = 1'b0; win_ready5 = 1'b0; pix_data5 = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    chk1("reset_busy5", busy5, 1'b0);
    chk1("reset_pix_ready5", pix_ready5, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    run_frame(0, 1'b1, 1'b0, 0, 1'b0);
    chk_ramp_windows();
    run_frame(1, 1'b1, 1'b0, 0, 1'b0);
    run_frame(2, 1'b0, 1'b0, 0, 1'b0);
    run_frame(0, 1'b1, 1'b0, 44, 1'b0);
    run_frame(0, 1'b1, 1'b0, 0, 1'b0);
    chk_ramp_windows();
    run_frame(0, 1'b0, 1'b1, 0, 1'b1);
    run_frame(3, 1'b0, 1'b1, 0, 1'b0);

    for (int k = 0; k < 25; k++) begin
      p5[k] = 8'($urandom);
      exp5[8*k +: 8] = p5[k];
    end
    @(negedge clk);
    start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    for (int k = 0; k < 25; k++) begin
      pix_valid5 = 1'b1;
      pix_data5  = p5[k];
      #1;
      chk1("w5_pix_ready", pix_ready5, 1'b1);
      chk1("w5_no_window", win_valid5, 1'b0);
      @(negedge clk);
    end
    pix_valid5 = 1'b0;
    win_ready5 = 1'b0;
    #1;
    chk1("w5_win_valid", win_valid5, 1'b1);
    chkw("w5_win_data", win_data5, exp5);
    chk1("w5_win_last", win_last5, 1'b1);
    chk1("w5_pix_ready_after", pix_ready5, 1'b0);
    @(negedge clk);
    win_ready5 = 1'b1;
    #1;
    chkw("w5_win_held", win_data5, exp5);
    @(negedge clk);
    win_ready5 = 1'b0;
    #1;
    chk1("w5_win_cleared", win_valid5, 1'b0);
    chk1("w5_res_early", res_valid5, 1'b0);
    @(negedge clk);
    #1;
    chk1("w5_res_valid", res_valid5, 1'b1);
    chk1("w5_res_last", res_last5, 1'b1);
    chk1("w5_done", done5, 1'b1);
    @(negedge clk);
    #1;
    chk1("w5_idle", busy5, 1'b0);
    chk1("w5_done_pulse", done5, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
